// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller driving the byte-lane data memory.
// Accepts one request at a time, checks legality, runs one aligned memory
// cycle (or a sequence of byte cycles for misaligned accesses) and returns
// a one-cycle completion pulse carrying extended load data or an error.
// Optional feature: define LSU_MISALIGN_EN to split misaligned half/word
// accesses into byte accesses; otherwise they complete with resp_err.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        illegal;
  logic        aligned;
  logic        go_err;
  logic        op_we;
  logic [2:0]  first_func3;
  logic [31:0] first_wdata;

`ifdef LSU_MISALIGN_EN
  logic        split;
  logic        op_uns;
  logic [1:0]  cnt;
  logic [1:0]  cnt_last;
  logic [1:0]  cnt_nxt;
  logic [31:0] wdata_r;
  logic [31:0] acc;
  logic [31:0] acc_cur;
  logic [31:0] split_rdata;
  logic [31:0] addr_nxt;
`endif

  assign req_ready  = (state == IDLE) && rst_n;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == RESP);

  // Classify the incoming request and form the first memory cycle
  always_comb begin
    illegal = (req_func3[1:0] == 2'b11) || (req_func3 == 3'b110) ||
              (req_we && req_func3[2]);
    aligned = (req_func3[1:0] == 2'b00) ||
              ((req_func3[1:0] == 2'b01) && !req_addr[0]) ||
              ((req_func3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00));
`ifdef LSU_MISALIGN_EN
    go_err = illegal;
`else
    go_err = illegal || !aligned;
`endif
    first_func3 = req_func3;
    first_wdata = req_wdata << {req_addr[1:0], 3'b000};
`ifdef LSU_MISALIGN_EN
    if (!aligned) begin
      first_func3 = req_we ? 3'b000 : 3'b100;
      first_wdata = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
    end
`endif
  end

`ifdef LSU_MISALIGN_EN
  // Next byte step of a split access and the load result assembled so far
  always_comb begin
    cnt_nxt  = cnt + 2'd1;
    addr_nxt = mem_addr + 32'd1;
    acc_cur  = acc;
    acc_cur[{cnt, 3'b000} +: 8] = mem_rdata[7:0];
    split_rdata = acc_cur;
    if (cnt_last == 2'd1)
      split_rdata = op_uns ? {16'h0, acc_cur[15:0]}
                           : {{16{acc_cur[15]}}, acc_cur[15:0]};
  end
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = go_err ? RESP : ACCESS;
      ACCESS: begin
`ifdef LSU_MISALIGN_EN
        if (!split || (cnt == cnt_last)) state_nxt = RESP;
`else
        state_nxt = RESP;
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory port, response and split-access bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_func3  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      op_we      <= 1'b0;
`ifdef LSU_MISALIGN_EN
      split      <= 1'b0;
      op_uns     <= 1'b0;
      cnt        <= '0;
      cnt_last   <= '0;
      wdata_r    <= '0;
      acc        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_we      <= req_we;
            resp_err   <= go_err;
            resp_rdata <= '0;
            if (!go_err) begin
              mem_we    <= req_we;
              mem_func3 <= first_func3;
              mem_addr  <= req_addr;
              mem_wdata <= first_wdata;
`ifdef LSU_MISALIGN_EN
              split     <= !aligned;
              op_uns    <= req_func3[2];
              cnt       <= '0;
              cnt_last  <= (req_func3[1:0] == 2'b01) ? 2'd1 : 2'd3;
              wdata_r   <= req_wdata;
              acc       <= '0;
`endif
            end
          end
        end
        ACCESS: begin
`ifdef LSU_MISALIGN_EN
          if (split && (cnt != cnt_last)) begin
            // Advance to the next byte; each byte goes to the lane of its own address
            cnt       <= cnt_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= {24'h0, wdata_r[{cnt_nxt, 3'b000} +: 8]} << {addr_nxt[1:0], 3'b000};
            acc       <= acc_cur;
          end else begin
            mem_we     <= 1'b0;
            resp_rdata <= op_we ? '0 : (split ? split_rdata : mem_rdata);
            cnt        <= '0;
          end
`else
          mem_we     <= 1'b0;
          resp_rdata <= op_we ? '0 : mem_rdata;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a byte-addressed memory
// model. Expectations follow LSU_MISALIGN_EN when it is defined.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
    int          elat;
    int          ewe;
  } req_t;

  logic [32:0] sb_q[$];
  logic [31:0] addr_log[$];

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_func3  (mem_func3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Byte-lane memory: 1 KiB window, address bits [9:0]
  logic [7:0]  mem_b [0:1023];
  logic [31:0] rd_a;
  logic [31:0] rd_v;
  int unsigned rd_n;

  function automatic int unsigned acc_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] a, input int unsigned k);
    logic [31:0] t;
    t = a + k;
    return t[9:0];
  endfunction

  function automatic int unsigned wlane(input logic [31:0] a, input int unsigned k);
    logic [31:0] t;
    t = a + k;
    return int'(t[1:0]);
  endfunction

  // Combinational read: lane-selected and extended per mem_func3
  always_comb begin
    rd_v = '0;
    rd_a = '0;
    rd_n = acc_bytes(mem_func3);
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < rd_n) begin
        rd_a = mem_addr + k;
        rd_v[8*k +: 8] = mem_b[rd_a[9:0]];
      end
    end
    if (!mem_func3[2] && (rd_n == 1)) rd_v[31:8]  = {24{rd_v[7]}};
    if (!mem_func3[2] && (rd_n == 2)) rd_v[31:16] = {16{rd_v[15]}};
    mem_rdata = rd_v;
  end

  // Write at the clock edge ending each cycle with mem_we high
  always @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k < acc_bytes(mem_func3))
          mem_b[widx(mem_addr, k)] <= mem_wdata[8*wlane(mem_addr, k) +: 8];
      end
    end
  end

  function automatic req_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] erd, input logic eerr,
                              input int elat, input int ewe);
    req_t r;
    r.we = we; r.f3 = f3; r.a = a; r.wd = wd;
    r.erd = erd; r.eerr = eerr; r.elat = elat; r.ewe = ewe;
    return r;
  endfunction

  // Drive one request, push its expectation, collect the response (bounded)
  task automatic run_req(input req_t t, output logic [32:0] sb_e,
                         output logic [32:0] got, output int lat, output int wecnt);
    sb_q.push_back({t.eerr, t.erd});
    addr_log.delete();
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = t.we;
    req_func3 = t.f3;
    req_addr  = t.a;
    req_wdata = t.wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat   = -1;
    wecnt = 0;
    got   = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_we) wecnt++;
      if (resp_valid) begin
        lat = c;
        got = {resp_err, resp_rdata};
        break;
      end
      addr_log.push_back(mem_addr);
    end
    sb_e = sb_q.pop_front();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctl: ready/valid/err/we=%b expected 0000",
               {req_ready, resp_valid, resp_err, mem_we});
    end
    tests++;
    if ({mem_func3, mem_addr, mem_wdata, resp_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_data: func3=%0h addr=%08h wdata=%08h rdata=%08h expected all 0",
               mem_func3, mem_addr, mem_wdata, resp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_word;
    req_t t[$];
    logic [32:0] e, g;
    int lat, wecnt;
    t.push_back(mk(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1));
    t.push_back(mk(1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0));
    foreach (t[i]) begin
      run_req(t[i], e, g, lat, wecnt);
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL word[%0d] resp: err=%b rdata=%08h expected err=%b rdata=%08h",
                 i, g[32], g[31:0], e[32], e[31:0]);
      end
      tests++;
      if (lat != t[i].elat || wecnt != t[i].ewe) begin
        fails++;
        $display("FAIL word[%0d] timing: latency=%0d we_cycles=%0d expected %0d/%0d",
                 i, lat, wecnt, t[i].elat, t[i].ewe);
      end
      if (i == 0) begin
        tests++;
        if (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h100 || mem_func3 !== 3'b010) begin
          fails++;
          $display("FAIL word_port: wdata=%08h addr=%08h func3=%0h expected deadbeef/00000100/2",
                   mem_wdata, mem_addr, mem_func3);
        end
      end
    end
  endtask

  task automatic test_byte;
    req_t t[$];
    logic [32:0] e, g;
    int lat, wecnt;
    t.push_back(mk(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1'b0, 2, 1));
    t.push_back(mk(1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFA5, 1'b0, 2, 0));
    t.push_back(mk(1'b0, 3'b100, 32'h103, 32'h0,        32'h000000A5, 1'b0, 2, 0));
    t.push_back(mk(1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFFA5AD, 1'b0, 2, 0));
    t.push_back(mk(1'b0, 3'b101, 32'h102, 32'h0,        32'h0000A5AD, 1'b0, 2, 0));
    foreach (t[i]) begin
      run_req(t[i], e, g, lat, wecnt);
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL byte[%0d] resp: err=%b rdata=%08h expected err=%b rdata=%08h",
                 i, g[32], g[31:0], e[32], e[31:0]);
      end
      tests++;
      if (lat != t[i].elat || wecnt != t[i].ewe) begin
        fails++;
        $display("FAIL byte[%0d] timing: latency=%0d we_cycles=%0d expected %0d/%0d",
                 i, lat, wecnt, t[i].elat, t[i].ewe);
      end
      if (i == 0) begin
        tests++;
        if (mem_wdata !== 32'hA5000000 || mem_func3 !== 3'b000) begin
          fails++;
          $display("FAIL byte_port: wdata=%08h func3=%0h expected a5000000/0", mem_wdata, mem_func3);
        end
      end
    end
  endtask

  task automatic test_misaligned;
    req_t t[$];
    logic [32:0] e, g;
    int lat, wecnt;
    t.push_back(mk(1'b1, 3'b010, 32'h100, 32'h44332211, 32'h0, 1'b0, 2, 1));
    t.push_back(mk(1'b1, 3'b010, 32'h104, 32'h88776655, 32'h0, 1'b0, 2, 1));
    t.push_back(mk(1'b1, 3'b000, 32'hFFFFFFFF, 32'h000000C3, 32'h0, 1'b0, 2, 1));
    t.push_back(mk(1'b1, 3'b000, 32'h0, 32'h0000009A, 32'h0, 1'b0, 2, 1));
`ifdef LSU_MISALIGN_EN
    t.push_back(mk(1'b0, 3'b010, 32'h101, 32'h0, 32'h55443322, 1'b0, 5, 0));
    t.push_back(mk(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 32'h00009AC3, 1'b0, 3, 0));
    t.push_back(mk(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFF9AC3, 1'b0, 3, 0));
    t.push_back(mk(1'b1, 3'b010, 32'h202, 32'h11223344, 32'h0, 1'b0, 5, 4));
    t.push_back(mk(1'b0, 3'b101, 32'h202, 32'h0, 32'h00003344, 1'b0, 2, 0));
    t.push_back(mk(1'b0, 3'b101, 32'h204, 32'h0, 32'h00001122, 1'b0, 2, 0));
`else
    t.push_back(mk(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b1, 3'b010, 32'h202, 32'h11223344, 32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b0, 3'b101, 32'h202, 32'h0, 32'h0, 1'b0, 2, 0));
    t.push_back(mk(1'b0, 3'b101, 32'h204, 32'h0, 32'h0, 1'b0, 2, 0));
`endif
    foreach (t[i]) begin
      run_req(t[i], e, g, lat, wecnt);
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL misaligned[%0d] resp: err=%b rdata=%08h expected err=%b rdata=%08h",
                 i, g[32], g[31:0], e[32], e[31:0]);
      end
      tests++;
      if (lat != t[i].elat || wecnt != t[i].ewe) begin
        fails++;
        $display("FAIL misaligned[%0d] timing: latency=%0d we_cycles=%0d expected %0d/%0d",
                 i, lat, wecnt, t[i].elat, t[i].ewe);
      end
      tests++;
      if (addr_log.size() != t[i].elat - 1) begin
        fails++;
        $display("FAIL misaligned[%0d] access_count: %0d expected %0d",
                 i, addr_log.size(), t[i].elat - 1);
      end else begin
        foreach (addr_log[k]) begin
          tests++;
          if (addr_log[k] !== t[i].a + 32'(k)) begin
            fails++;
            $display("FAIL misaligned[%0d] addr%0d: %08h expected %08h",
                     i, k, addr_log[k], t[i].a + 32'(k));
          end
        end
      end
    end
  endtask

  task automatic test_illegal;
    req_t t[$];
    logic [32:0] e, g;
    int lat, wecnt;
    t.push_back(mk(1'b0, 3'b011, 32'h100, 32'h0,        32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b1, 3'b100, 32'h100, 32'h12345678, 32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b0, 3'b110, 32'h100, 32'h0,        32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b1, 3'b011, 32'h100, 32'hCAFEBABE, 32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b1, 3'b101, 32'h100, 32'hCAFEBABE, 32'h0, 1'b1, 1, 0));
    t.push_back(mk(1'b0, 3'b010, 32'h100, 32'h0, 32'h44332211, 1'b0, 2, 0));
    foreach (t[i]) begin
      run_req(t[i], e, g, lat, wecnt);
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL illegal[%0d] resp: err=%b rdata=%08h expected err=%b rdata=%08h",
                 i, g[32], g[31:0], e[32], e[31:0]);
      end
      tests++;
      if (lat != t[i].elat || wecnt != t[i].ewe) begin
        fails++;
        $display("FAIL illegal[%0d] timing: latency=%0d we_cycles=%0d expected %0d/%0d",
                 i, lat, wecnt, t[i].elat, t[i].ewe);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0]  exp_rdy;
    logic [32:0] e;
    int resp_at[$];
    exp_rdy = 6'b100100;
    sb_q.push_back({1'b0, 32'h44332211});
    sb_q.push_back({1'b0, 32'h44332211});
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_func3 = 3'b010;
    req_addr  = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 4) req_valid = 1'b0;
      tests++;
      if (req_ready !== exp_rdy[c-1]) begin
        fails++;
        $display("FAIL b2b ready cycle %0d: %b expected %b", c, req_ready, exp_rdy[c-1]);
      end
      if (resp_valid) begin
        resp_at.push_back(c);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          tests++;
          if ({resp_err, resp_rdata} !== e) begin
            fails++;
            $display("FAIL b2b resp: err=%b rdata=%08h expected err=%b rdata=%08h",
                     resp_err, resp_rdata, e[32], e[31:0]);
          end
        end
      end
    end
    tests++;
    if (resp_at.size() != 2 || sb_q.size() != 0) begin
      fails++;
      $display("FAIL b2b resp_count: %0d responses, %0d left expected 2/0",
               resp_at.size(), sb_q.size());
    end else begin
      tests++;
      if (resp_at[0] != 2 || resp_at[1] != 5) begin
        fails++;
        $display("FAIL b2b resp_cycles: %0d,%0d expected 2,5", resp_at[0], resp_at[1]);
      end
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid;
    int bad_we;
    int bad_resp;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_wdata = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_EN
    req_addr  = 32'h202;
`else
    req_addr  = 32'h200;
`endif
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid first_access: mem_we=%b expected 1", mem_we);
    end
`ifdef LSU_MISALIGN_EN
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h203) begin
      fails++;
      $display("FAIL rst_mid second_access: mem_we=%b addr=%08h expected 1/00000203", mem_we, mem_addr);
    end
`endif
    rst_n = 1'b0;
    bad_we = 0;
    bad_resp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) bad_we++;
      if (resp_valid) bad_resp++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid ready: req_ready=%b expected 1", req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_we) bad_we++;
      if (resp_valid) bad_resp++;
    end
    tests++;
    if (bad_we != 0 || bad_resp != 0) begin
      fails++;
      $display("FAIL rst_mid quiet: we_cycles=%0d resp_cycles=%0d expected 0/0", bad_we, bad_resp);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_misaligned();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
